switch_debounce: RTL and testbench

Synchronises and debounces the raw board switch inputs before they reach the AHB-Lite GPIO peripheral's `GPIOIN[7:0]`. It sits directly upstream of that peripheral and runs in the `HCLK` domain. It delivers glitch-free levels, one-cycle rise/fall event pulses and sticky per-bit change flags, and produces an aggregated interrupt request intended for a CPU `IRQ` line that is currently tied low.

---
 rtl/switch_debounce_pkg.sv | 18 +
 rtl/switch_debounce_if.sv | 24 ++
 rtl/switch_debounce_chan.sv | 83 ++++++++
 rtl/switch_debounce.sv | 49 ++++
 tb/tb_switch_debounce.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared constants and types for the switch synchroniser/debouncer.
package switch_debounce_pkg;

  localparam int DEBOUNCE_1MS_25MHZ = 25000;
  localparam int DEBOUNCE_CNT_W     = 16;
  localparam int DEBOUNCE_SIM       = 4;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } chan_state_e;

  // True when the qualify count is non-zero and reachable without wrapping.
  function automatic bit debounce_cfg_ok(input int cycles, input int cnt_w);
    return (cycles > 0) && (longint'(cycles) <= (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Switch-side signal bundle; master drives raw levels and clears, slave is the debouncer.
// No valid/ready: SW_OUT/CHANGED/IRQ are levels, RISE/FALL are one-cycle pulses, CLR_CHANGED acts on the next edge.
interface switch_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] SW_IN;
  logic [WIDTH-1:0] CLR_CHANGED;
  logic [WIDTH-1:0] SW_OUT;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic [WIDTH-1:0] CHANGED;
  logic             IRQ;
  logic [WIDTH-1:0] dbg_qualify;

  modport master (
    output SW_IN, CLR_CHANGED,
    input  SW_OUT, RISE, FALL, CHANGED, IRQ, dbg_qualify
  );

  modport slave (
    input  SW_IN, CLR_CHANGED,
    output SW_OUT, RISE, FALL, CHANGED, IRQ, dbg_qualify
  );
endinterface

// File: rtl/switch_debounce_chan.sv
// One switch channel: 2-FF synchroniser, qualify counter FSM, edge pulses and sticky change flag.
module debounce_chan
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_25MHZ,
  parameter int CNT_W           = DEBOUNCE_CNT_W
) (
  input  logic        HCLK,
  input  logic        RESET,
  input  logic        sw_in,
  input  logic        clr_changed,
  output logic        sw_out,
  output logic        rise,
  output logic        fall,
  output logic        changed,
  output chan_state_e state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             db;
  logic [CNT_W-1:0] cnt;

  chan_state_e      next_state;
  logic [CNT_W-1:0] next_cnt;
  logic             accept;
  logic             rise_d;
  logic             fall_d;

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db      <= 1'b0;
      cnt     <= '0;
      state   <= ST_STABLE;
      rise    <= 1'b0;
      fall    <= 1'b0;
      changed <= 1'b0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      state <= next_state;
      cnt   <= next_cnt;
      rise  <= rise_d;
      fall  <= fall_d;
      if (accept) begin
        db <= sync2;
      end
      // A set on the same edge as a clear wins so no transition is lost.
      if (accept) begin
        changed <= 1'b1;
      end else if (clr_changed) begin
        changed <= 1'b0;
      end
    end
  end

  // Any cycle where the synchronised level matches db drops the partial count.
  always_comb begin
    next_state = ST_STABLE;
    next_cnt   = '0;
    accept     = 1'b0;
    if (sync2 != db) begin
      if (cnt == CNT_LAST) begin
        accept = 1'b1;
      end else begin
        next_state = ST_QUALIFY;
        next_cnt   = cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rise_d = accept & sync2;
    fall_d = accept & ~sync2;
  end

  assign sw_out = db;

endmodule

// File: rtl/switch_debounce.sv
// Debounces WIDTH independent switch channels and raises a registered IRQ from the sticky flags.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_25MHZ,
  parameter int CNT_W           = DEBOUNCE_CNT_W
) (
  input  logic             HCLK,
  input  logic             RESET,
  switch_debounce_if.slave sw
);

  if (!debounce_cfg_ok(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cfg
    $error("switch_debounce: DEBOUNCE_CYCLES must be in 1..2**CNT_W");
  end

  chan_state_e chan_state [WIDTH];
  logic        irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .HCLK        (HCLK),
      .RESET       (RESET),
      .sw_in       (sw.SW_IN[i]),
      .clr_changed (sw.CLR_CHANGED[i]),
      .sw_out      (sw.SW_OUT[i]),
      .rise        (sw.RISE[i]),
      .fall        (sw.FALL[i]),
      .changed     (sw.CHANGED[i]),
      .state       (chan_state[i])
    );
    assign sw.dbg_qualify[i] = (chan_state[i] == ST_QUALIFY);
  end

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |sw.CHANGED;
    end
  end

  assign sw.IRQ = irq_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_switch_debounce;
  import switch_debounce_pkg::*;

  typedef struct {
    logic       rst;
    logic [7:0] sw;
    logic [7:0] clr;
    logic [7:0] e_out;
    logic [7:0] e_rise;
    logic [7:0] e_fall;
    logic [7:0] e_chg;
    logic       e_irq;
  } vec_t;

  logic HCLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  switch_debounce_if #(.WIDTH(8)) sw_if ();

  switch_debounce #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (DEBOUNCE_SIM),
    .CNT_W           (DEBOUNCE_CNT_W)
  ) dut (
    .HCLK  (HCLK),
    .RESET (RESET),
    .sw    (sw_if.slave)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  // driver tasks
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic [7:0] sw, input logic [7:0] clr,
                              input logic [7:0] e_out, input logic [7:0] e_rise,
                              input logic [7:0] e_fall, input logic [7:0] e_chg, input logic e_irq);
    vec_t v;
    v.rst = rst; v.sw = sw; v.clr = clr;
    v.e_out = e_out; v.e_rise = e_rise; v.e_fall = e_fall; v.e_chg = e_chg; v.e_irq = e_irq;
    vecs.push_back(v);
  endfunction

  initial begin
    int rise_cnt;
    int fall_cnt;
    int rise_edge;

    RESET = 1'b1;
    sw_if.SW_IN = 8'h00;
    sw_if.CLR_CHANGED = 8'h00;

    // reset with switches high, then rise accepted at edge 5
    for (int i = 0; i < 3; i++) add(1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++) add(0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 0);
    add(0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 1);
    add(0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1);
    add(0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    // all channels fall
    for (int i = 0; i < 5; i++) add(0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
    add(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1);
    add(0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    add(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    // clean edge on bit 0
    for (int i = 0; i < 5; i++) add(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 0);
    add(0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1);
    add(0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1);
    add(0, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1);
    add(0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    // 3-cycle glitch on bit 3 is rejected
    for (int i = 0; i < 3; i++) add(0, 8'h09, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 7; i++) add(0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      RESET = vecs[i].rst;
      sw_if.SW_IN = vecs[i].sw;
      sw_if.CLR_CHANGED = vecs[i].clr;
      tick();
      check($sformatf("v%0d sw_out", i), sw_if.SW_OUT, vecs[i].e_out);
      check($sformatf("v%0d rise", i), sw_if.RISE, vecs[i].e_rise);
      check($sformatf("v%0d fall", i), sw_if.FALL, vecs[i].e_fall);
      check($sformatf("v%0d changed", i), sw_if.CHANGED, vecs[i].e_chg);
      check($sformatf("v%0d irq", i), 8'(sw_if.IRQ), 8'(vecs[i].e_irq));
    end
    sw_if.CLR_CHANGED = 8'h00;

    // bounce on bit 7, then hold high
    rise_cnt = 0;
    fall_cnt = 0;
    rise_edge = -1;
    for (int k = 0; k < 10; k++) begin
      sw_if.SW_IN = (k % 2 == 0) ? 8'h81 : 8'h01;
      tick();
      if (sw_if.RISE[7]) rise_cnt++;
      if (sw_if.FALL[7]) fall_cnt++;
    end
    sw_if.SW_IN = 8'h81;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (sw_if.RISE[7]) begin
        rise_cnt++;
        rise_edge = j;
      end
      if (sw_if.FALL[7]) fall_cnt++;
    end
    check("bounce rise count", 8'(rise_cnt), 8'd1);
    check("bounce rise edge", 8'(rise_edge), 8'd5);
    check("bounce fall count", 8'(fall_cnt), 8'd0);
    check("bounce sw_out", sw_if.SW_OUT, 8'h81);
    check("bounce changed", sw_if.CHANGED, 8'h80);

    // set/clear collision on bit 0 falling
    sw_if.CLR_CHANGED = 8'hFF;
    tick();
    sw_if.CLR_CHANGED = 8'h00;
    tick();
    check("pre-collision changed", sw_if.CHANGED, 8'h00);
    check("pre-collision irq", 8'(sw_if.IRQ), 8'h00);
    sw_if.SW_IN = 8'h80;
    for (int j = 0; j < 5; j++) tick();
    check("pre-accept sw_out", sw_if.SW_OUT, 8'h81);
    sw_if.CLR_CHANGED = 8'h01;
    tick();
    check("collision fall", sw_if.FALL, 8'h01);
    check("collision changed", sw_if.CHANGED, 8'h01);
    sw_if.CLR_CHANGED = 8'h00;
    tick();
    check("collision hold changed", sw_if.CHANGED, 8'h01);
    check("collision irq", 8'(sw_if.IRQ), 8'h01);
    sw_if.CLR_CHANGED = 8'h01;
    tick();
    check("second clear changed", sw_if.CHANGED, 8'h00);
    sw_if.CLR_CHANGED = 8'h00;
    tick();
    check("second clear irq", 8'(sw_if.IRQ), 8'h00);

    // reset while bit 2 qualifies with cnt=2
    sw_if.SW_IN = 8'h84;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("mid q%0d rise", j), sw_if.RISE, 8'h00);
      check($sformatf("mid q%0d sw_out", j), sw_if.SW_OUT, 8'h80);
    end
    check("mid qualify state", sw_if.dbg_qualify, 8'h04);
    RESET = 1'b1;
    tick();
    check("mid reset sw_out", sw_if.SW_OUT, 8'h00);
    check("mid reset dbg", sw_if.dbg_qualify, 8'h00);
    check("mid reset changed", sw_if.CHANGED, 8'h00);
    RESET = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j < 5) begin
        check($sformatf("requal e%0d rise", j), sw_if.RISE, 8'h00);
        check($sformatf("requal e%0d sw_out", j), sw_if.SW_OUT, 8'h00);
      end else begin
        check("requal accept rise", sw_if.RISE, 8'h84);
        check("requal accept sw_out", sw_if.SW_OUT, 8'h84);
        check("requal accept changed", sw_if.CHANGED, 8'h84);
      end
    end
    tick();
    check("requal rise drop", sw_if.RISE, 8'h00);
    check("requal irq", 8'(sw_if.IRQ), 8'h01);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
